// File: rtl/uart_tx8.sv
// 8N1 UART transmitter with a one-byte holding register so back-to-back frames
// leave the line with no idle bit between them.
module uart_tx8 #(
  parameter int unsigned CLOCK_RATE = 12000000,
  parameter int unsigned BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] txIn,
  output logic       txReady,
  output logic       txBusy,
  output logic       txDone,
  output logic       txOut
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txStateT;

  txStateT          state;
  logic [7:0]       holdReg;
  logic [7:0]       shiftReg;
  logic [2:0]       bitIdx;
  logic [CNT_W-1:0] baudCnt;

  logic holdFull;
  logic lastTick;
  logic loadNow;

  // txReady is the registered inverse of the holding-register-full flag.
  assign holdFull = ~txReady;
  assign lastTick = (baudCnt == CNT_LAST);
  assign loadNow  = holdFull & txEn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      holdReg  <= 8'h00;
      shiftReg <= 8'h00;
      bitIdx   <= 3'd0;
      baudCnt  <= '0;
      txReady  <= 1'b1;
      txBusy   <= 1'b0;
      txDone   <= 1'b0;
      txOut    <= 1'b1;
    end else begin
      txDone <= 1'b0;

      // Accept and hold->shift transfer are mutually exclusive: one needs txReady, the other !txReady.
      if (txStart && txReady) begin
        holdReg <= txIn;
        txReady <= 1'b0;
      end

      case (state)
        IDLE: begin
          txOut   <= 1'b1;
          txBusy  <= 1'b0;
          baudCnt <= '0;
          if (loadNow) begin
            shiftReg <= holdReg;
            txReady  <= 1'b1;
            state    <= START;
            txOut    <= 1'b0;
            txBusy   <= 1'b1;
          end
        end

        START: begin
          if (lastTick) begin
            baudCnt <= '0;
            bitIdx  <= 3'd0;
            state   <= DATA;
            txOut   <= shiftReg[0];
          end else begin
            baudCnt <= baudCnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (lastTick) begin
            baudCnt <= '0;
            if (bitIdx == 3'd7) begin
              state <= STOP;
              txOut <= 1'b1;
            end else begin
              bitIdx <= bitIdx + 3'd1;
              txOut  <= shiftReg[bitIdx + 3'd1];
            end
          end else begin
            baudCnt <= baudCnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (lastTick) begin
            baudCnt <= '0;
            txDone  <= 1'b1;
            // A queued byte starts on the same edge, so no idle bit separates the frames.
            if (loadNow) begin
              shiftReg <= holdReg;
              txReady  <= 1'b1;
              state    <= START;
              txOut    <= 1'b0;
            end else begin
              state  <= IDLE;
              txBusy <= 1'b0;
            end
          end else begin
            baudCnt <= baudCnt + CNT_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          baudCnt <= '0;
          txOut   <= 1'b1;
          txBusy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx8.sv
// Self-checking bench for uart_tx8: directed vectors, corner sequences and a
// randomized run checked against a frame-position reference model and a line decoder.
module tb_uart_tx8;

  localparam int unsigned CLOCK_RATE = 153600;
  localparam int unsigned BAUD_RATE  = 9600;
  localparam int N = CLOCK_RATE / BAUD_RATE;  // 16 clocks per bit

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       txEn = 1'b0;
  logic       txStart = 1'b0;
  logic [7:0] txIn = 8'h00;
  logic       txReady, txBusy, txDone, txOut;

  always #5 clk = ~clk;

  uart_tx8 #(.CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .reset(reset), .txEn(txEn), .txStart(txStart), .txIn(txIn),
    .txReady(txReady), .txBusy(txBusy), .txDone(txDone), .txOut(txOut)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a frame is a 10*N-clock window; position/N selects start, data or stop bit.
  bit         mBusy, mHold, mDone, mEnd, mGo, mReady;
  int         mPos;
  logic [7:0] mByte, mHoldByte;
  logic [7:0] expQ[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mBusy = 0; mHold = 0; mDone = 0; mPos = 0;
    end else begin
      mReady = !mHold;
      mEnd   = mBusy && (mPos == 10 * N - 1);
      mGo    = mHold && txEn && (!mBusy || mEnd);
      mDone  = mEnd;
      if (mEnd) mBusy = 0;
      else if (mBusy) mPos++;
      if (mGo) begin
        mBusy = 1; mPos = 0; mByte = mHoldByte; mHold = 0;
        expQ.push_back(mHoldByte);
      end
      if (txStart && mReady) begin
        mHold = 1; mHoldByte = txIn;
      end
    end
  end

  function automatic logic modelLine();
    int k;
    if (!mBusy) return 1'b1;
    k = mPos / N;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return mByte[k-1];
  endfunction

  // Every cycle: compare all four outputs with the model.
  always @(negedge clk)
    if (!reset)
      check("cycle", 32'({txOut, txReady, txBusy, txDone}),
            32'({modelLine(), !mHold, mBusy, mDone}));

  // Event counters and a mid-bit sampling line decoder.
  int         doneCnt = 0, busyCnt = 0, rxErr = 0, rxCnt = -1;
  logic [9:0] rxSh;
  logic [7:0] rxQ[$];

  always @(negedge clk) begin
    if (txDone) doneCnt++;
    if (txBusy) busyCnt++;
  end

  always @(negedge clk or posedge reset) begin
    if (reset) rxCnt = -1;
    else if (rxCnt < 0) begin
      if (txOut == 1'b0) rxCnt = 0;
    end else begin
      rxCnt++;
      if (rxCnt % N == N / 2) rxSh[rxCnt / N] = txOut;
      if (rxCnt == 9 * N + N / 2) begin
        if (rxSh[0] != 1'b0 || rxSh[9] != 1'b1) rxErr++;
        rxQ.push_back(rxSh[8:1]);
        rxCnt = -1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [7:0] b);
    txIn = b;
    txStart = 1'b1;
    tick(1);
    txStart = 1'b0;
    txIn = 8'($urandom);
  endtask

  task automatic waitStart(input string name);
    int i;
    for (i = 0; i < 40 * N && txOut != 1'b0; i++) tick(1);
    check(name, 32'(txOut), 32'(0));
  endtask

  // Called at the first cycle of a start bit; samples the middle of each of the ten bits.
  task automatic sampleFrame(output logic [9:0] got);
    for (int j = 0; j < 10; j++) begin
      tick(j == 0 ? N / 2 : N);
      got[j] = txOut;
    end
  endtask

  task automatic waitIdle(input string name);
    int i;
    for (i = 0; i < 40 * N && (txBusy || !txReady); i++) tick(1);
    check(name, 32'({txBusy, txReady}), 32'(2'b01));
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
  } vecT;

  vecT        vecs[6];
  logic [9:0] got;
  logic [7:0] loopBytes[3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hD6, 10'b1110101100};
    vecs[1] = '{8'h55, 10'b1010101010};
    vecs[2] = '{8'hA3, 10'b1101000110};
    vecs[3] = '{8'h00, 10'b1000000000};
    vecs[4] = '{8'hFF, 10'b1111111110};
    vecs[5] = '{8'h3C, 10'b1001111000};

    // Reset and idle
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 100; i++)
      check("idle", 32'({txOut, txReady, txBusy, txDone}), 32'(4'b1100));
    tick(1);

    // Table-driven single frames: latency, line bits, busy length, one done pulse
    txEn = 1'b1;
    for (int v = 0; v < 6; v++) begin
      busyCnt = 0;
      doneCnt = 0;
      load(vecs[v].data);
      check("latency_e0", 32'(txOut), 32'(1));
      tick(1);
      check("latency_e1", 32'(txOut), 32'(0));
      sampleFrame(got);
      check($sformatf("line_%02h", vecs[v].data), 32'(got), 32'(vecs[v].line));
      tick(N);
      check("busy_len", 32'(busyCnt), 32'(10 * N));
      check("done_cnt", 32'(doneCnt), 32'(1));
    end

    // Back-to-back frames, third strobe dropped while holding register is full
    load(8'h55);
    waitStart("b2b_start");
    load(8'hA3);
    check("hold_full", 32'(txReady), 32'(0));
    load(8'h99);
    check("drop_ready", 32'(txReady), 32'(0));
    tick(10 * N - 3);
    check("b2b_stop", 32'({txOut, txReady}), 32'(2'b10));
    tick(1);
    check("b2b_gap0", 32'({txOut, txReady}), 32'(2'b01));
    sampleFrame(got);
    check("b2b_second", 32'(got), 32'(10'b1101000110));
    tick(3 * N);
    check("b2b_no_third", 32'({txOut, txBusy}), 32'(2'b10));

    // Enable gating: byte held until txEn returns
    txEn = 1'b0;
    load(8'h3C);
    tick(3 * N);
    check("en_hold", 32'({txOut, txReady, txBusy}), 32'(3'b100));
    txEn = 1'b1;
    tick(1);
    check("en_latency", 32'(txOut), 32'(0));
    sampleFrame(got);
    check("en_frame", 32'(got), 32'(10'b1001111000));
    tick(N);

    // Asynchronous reset during data bit 3
    load(8'h00);
    waitStart("abort_start");
    tick(4 * N + N / 2);
    check("abort_pre", 32'({txOut, txBusy}), 32'(2'b01));
    doneCnt = 0;
    reset = 1'b1;
    #1;
    check("abort_async", 32'({txOut, txReady, txBusy, txDone}), 32'(4'b1100));
    #1;
    reset = 1'b0;
    tick(20 * N);
    check("abort_no_done", 32'(doneCnt), 32'(0));
    load(8'hD6);
    waitStart("post_abort_start");
    sampleFrame(got);
    check("post_abort_frame", 32'(got), 32'(10'b1110101100));
    tick(N);

    // Loopback decode of back-to-back bytes
    rxQ.delete();
    rxErr = 0;
    doneCnt = 0;
    loopBytes[0] = 8'h00;
    loopBytes[1] = 8'hFF;
    loopBytes[2] = 8'hD6;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 40 * N && !txReady; i++) tick(1);
      check("loop_ready", 32'(txReady), 32'(1));
      load(loopBytes[b]);
    end
    waitIdle("loop_idle");
    check("loop_count", 32'(rxQ.size()), 32'(3));
    for (int b = 0; b < 3; b++)
      if (b < rxQ.size()) check("loop_byte", 32'(rxQ[b]), 32'(loopBytes[b]));
    check("loop_err", 32'(rxErr), 32'(0));
    check("loop_done", 32'(doneCnt), 32'(3));

    // Randomized traffic with txEn toggling
    rxQ.delete();
    expQ.delete();
    rxErr = 0;
    for (int i = 0; i < 4000; i++) begin
      txEn    = ($urandom_range(0, 7) != 0);
      txStart = ($urandom_range(0, 15) == 0);
      txIn    = 8'($urandom);
      tick(1);
    end
    txStart = 1'b0;
    txEn = 1'b1;
    waitIdle("rand_idle");
    tick(2);
    check("rand_count", 32'(rxQ.size()), 32'(expQ.size()));
    for (int b = 0; b < expQ.size(); b++)
      if (b < rxQ.size()) check("rand_byte", 32'(rxQ[b]), 32'(expQ[b]));
    check("rand_err", 32'(rxErr), 32'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
